// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: FSM encoding, round
// count, index width and the round-constant helper.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_RW = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key schedule: cleared to 01, advanced by
// one xtime step per enabled cycle.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] rcon
);

    logic [7:0] rcon_r;

    // Round-constant register; clear wins over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_r <= RCON_INIT;
        end else if (clr) begin
            rcon_r <= RCON_INIT;
        end else if (en) begin
            rcon_r <= xtime(rcon_r);
        end else begin
            rcon_r <= rcon_r;
        end
    end

    assign rcon = rcon_r;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts one block, steps LOAD, nine full rounds,
// the final round, then holds the result until the consumer takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int RW = AES_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ld_state,
    output logic          round_en,
    output logic          final_rnd,
    output logic          key_en,
    output logic [RW-1:0] round_idx,
    output logic [7:0]    rcon,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    state_e        state_r;
    state_e        state_s;
    logic [RW-1:0] idx_r;
    logic [RW-1:0] idx_s;

    logic in_ready_s, ld_state_s, round_en_s, final_rnd_s, key_en_s, out_valid_s, busy_s;
    logic in_ready_r, ld_state_r, round_en_r, final_rnd_r, key_en_r, out_valid_r, busy_r;

    // State and round-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state and next-index logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                idx_s = '0;
                if (in_valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_ROUND;
                idx_s   = RW'(1);
            end
            ST_ROUND: begin
                idx_s = idx_r + RW'(1);
                if (idx_r == RW'(NR - 1)) begin
                    state_s = ST_FINAL;
                end else begin
                    state_s = ST_ROUND;
                end
            end
            ST_FINAL: begin
                state_s = ST_DONE;
                idx_s   = RW'(NR);
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                end else begin
                    state_s = ST_DONE;
                    idx_s   = idx_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state, so every output leaves a flop.
    always_comb begin
        in_ready_s  = 1'b0;
        ld_state_s  = 1'b0;
        round_en_s  = 1'b0;
        final_rnd_s = 1'b0;
        key_en_s    = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_s)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_LOAD: begin
                ld_state_s = 1'b1;
            end
            ST_ROUND: begin
                round_en_s = 1'b1;
                key_en_s   = 1'b1;
            end
            ST_FINAL: begin
                round_en_s  = 1'b1;
                key_en_s    = 1'b1;
                final_rnd_s = 1'b1;
            end
            ST_DONE: begin
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            ld_state_r  <= 1'b0;
            round_en_r  <= 1'b0;
            final_rnd_r <= 1'b0;
            key_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            ld_state_r  <= ld_state_s;
            round_en_r  <= round_en_s;
            final_rnd_r <= final_rnd_s;
            key_en_r    <= key_en_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // rcon steps at the end of each full round, so FINAL sees the tenth constant.
    aes_rcon_gen u_rcon (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == ST_ROUND),
        .clr   (state_r != ST_ROUND),
        .rcon  (rcon)
    );

    assign in_ready  = in_ready_r;
    assign ld_state  = ld_state_r;
    assign round_en  = round_en_r;
    assign final_rnd = final_rnd_r;
    assign key_en    = key_en_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign round_idx = idx_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: a block-level model predicts the event
// timeline per accepted block; a monitor checks each DUT event against it.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, ld_state, round_en, final_rnd, key_en, out_valid, busy;
    logic [3:0] round_idx;
    logic [7:0] rcon;

    aes_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_state  (ld_state),
        .round_en  (round_en),
        .final_rnd (final_rnd),
        .key_en    (key_en),
        .round_idx (round_idx),
        .rcon      (rcon),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;   // 0 load, 1 round, 2 result
        int         idx;
        logic [7:0] rc;
        bit         fin;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   m_t = -1;         // cycles since acceptance, -1 when idle, 12 while result is held
    logic ov_prev = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Key-schedule constant for round r from the doubling rule.
    function automatic logic [7:0] ref_rcon(input int r);
        int rc;
        rc = 1;
        for (int k = 1; k < r; k++) begin
            rc = rc << 1;
            if (rc > 255) rc = rc ^ 'h11B;
        end
        return rc[7:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ld_state", ld_state, 0);
        chk("rst_round_en", round_en, 0);
        chk("rst_key_en", key_en, 0);
        chk("rst_final_rnd", final_rnd, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_rcon", rcon, 1);
    endtask

    // Block-level reference model: on acceptance, queue the whole timeline.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= -1;
            q.delete();
        end else begin
            cyc <= cyc + 1;
            if (m_t < 0) begin
                if (in_valid) begin
                    m_t <= 1;
                    q.push_back('{cyc + 1, 0, 0, 8'h01, 1'b0});
                    for (int r = 1; r <= 10; r++)
                        q.push_back('{cyc + 1 + r, 1, r, ref_rcon(r), (r == 10)});
                    q.push_back('{cyc + 12, 2, 10, 8'h00, 1'b0});
                end
            end else if (m_t < 12) begin
                m_t <= m_t + 1;
            end else if (out_ready) begin
                m_t <= -1;
            end
        end
    end

    // Monitor: per-cycle handshake checks and event scoreboard.
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (rst_n) begin
            chk("in_ready", in_ready, (m_t < 0));
            chk("busy", busy, (m_t >= 0));
            chk("out_valid", out_valid, (m_t == 12));
            if (m_t == 12) begin
                chk("done_round_idx", round_idx, 10);
                chk("done_no_round_en", round_en, 0);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed_event_kind", -1, e.kind);
            end
            if (ld_state || round_en || (out_valid && !ov_prev)) begin
                kind = ld_state ? 0 : (round_en ? 1 : 2);
                if (q.size() == 0) begin
                    chk("unexpected_event_kind", kind, -1);
                end else begin
                    e = q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_kind", kind, e.kind);
                    chk("ev_round_idx", round_idx, e.idx);
                    chk("ev_final_rnd", final_rnd, e.fin);
                    chk("ev_key_en", key_en, (e.kind == 1));
                    if (e.kind != 2) chk("ev_rcon", rcon, e.rc);
                end
            end
        end
        ov_prev <= out_valid;
    end

    initial begin
        bit seen5;
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single block, consumer always ready.
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Backpressure: consumer stalls well past the result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // in_valid held high: busy rejection and back-to-back blocks.
        in_valid = 1'b1;
        repeat (45) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;

        // Reset while round 5 is in progress.
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        seen5 = 1'b0;
        for (int k = 0; k < 20 && !seen5; k++) begin
            @(negedge clk);
            if (round_idx == 4'd5) seen5 = 1'b1;
        end
        chk("reach_round5", seen5, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (m_t < 0 && q.size() == 0) break;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_idle", m_t, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES rounds; only 10 is supported for AES-128.
REQ-002 Parameter RW, default 4, width of the round index.
REQ-003 clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  requester has a plaintext and key block present on the datapath inputs.
REQ-006 in_ready  output  1  controller accepts a new block this cycle.
REQ-007 ld_state  output  1  datapath loads plaintext XOR key (round 0) and the cipher key into its registers.
REQ-008 round_en  output  1  datapath registers one round result this cycle.
REQ-009 final_rnd  output  1  qualifies round_en; datapath bypasses MixColumns.
REQ-010 key_en  output  1  key-expansion register advances this cycle.
REQ-011 round_idx  output  RW  current round number, 0..NR.
REQ-012 rcon  output  8  round constant for the key-expansion step taken this cycle.
REQ-013 out_valid  output  1  ciphertext on the datapath output is valid.
REQ-014 out_ready  input  1  consumer takes the ciphertext.
REQ-015 busy  output  1  a block is in flight (any state other than IDLE).

Function
REQ-016 FSM states: IDLE, LOAD, ROUND, FINAL, DONE; all outputs are registered or decoded from the state and round_idx only, with no path from in_valid or out_ready to a datapath enable.
REQ-017 IDLE: in_ready=1; on in_valid=1 -> LOAD. Otherwise stay in IDLE.
REQ-018 LOAD (1 cycle): ld_state=1, round_idx=0 -> ROUND with round_idx=1.
REQ-019 ROUND: round_en=1, key_en=1, final_rnd=0; round_idx increments each cycle; when round_idx=NR-1 -> FINAL.
REQ-020 FINAL (1 cycle): round_en=1, key_en=1, final_rnd=1, round_idx=NR -> DONE.
REQ-021 DONE: out_valid=1; hold until out_ready=1, then -> IDLE with round_idx=0. The datapath is not enabled in DONE.
REQ-022 Latency: handshake in cycle N; LOAD in N+1; rounds 1..9 in N+2..N+10; FINAL in N+11; out_valid rises in N+12.
REQ-023 Back-to-back operation: out_ready=1 in the first DONE cycle returns the FSM to IDLE the next cycle, so the throughput is one block per 13 cycles minimum.
REQ-024 rcon sequence for round_idx 1..10: 01,02,04,08,10,20,40,80,1B,36; each value is the GF(2^8) xtime of the previous value, with reduction by 0x1B; rcon=01 in LOAD and in IDLE.
REQ-025 in_ready=0 in every state except IDLE; in_valid asserted while busy is ignored and causes no state change.
REQ-026 out_ready while out_valid=0 has no effect.
REQ-027 round_idx never exceeds NR, and no counter wrap-around is reachable.

Reset
REQ-028 rst_n=0 forces the following immediately, without waiting for clk, including mid-operation:
- state=IDLE, round_idx=0, rcon=01;
- out_valid=0, ld_state=0, round_en=0, key_en=0, final_rnd=0, busy=0;
- in_ready=1.
REQ-029 After rst_n deasserts, the first in_valid is accepted on the first posedge clk; the aborted block produces no out_valid.

Structure
REQ-030 Shared package aes_pkg holds the FSM state encoding, NR, the round-index width, and the RCON_INIT constant 8'h01.
REQ-031 One sub-module, aes_rcon_gen, holds the rcon register and the xtime update (enable and clear inputs).
REQ-032 The target implementation size is 120-250 lines, with no latches and no combinational loops.

Verification
REQ-033 Single block: in_valid pulse at cycle 0, out_ready=1 held high. Required response:
- ld_state at cycle 1;
- round_en in cycles 2..11, with final_rnd only at cycle 11;
- out_valid at cycle 12 for exactly one cycle.
REQ-034 rcon trace: sample rcon in each round_en cycle; the sequence equals 01,02,04,08,10,20,40,80,1B,36.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid rises. Required response:
- out_valid stays 1 and round_idx stays 10;
- no round_en occurs;
- the FSM returns to IDLE one cycle after out_ready=1.
REQ-036 Busy rejection: in_valid held at 1 continuously. Required response:
- in_ready=0 during cycles 1..12;
- exactly one LOAD occurs per completed block;
- the next LOAD follows cycle 13.
REQ-037 Reset mid-operation: rst_n=0 while round_idx=5. Required response:
- all outputs take their reset values in the same time step;
- no out_valid appears;
- a new block launched afterwards completes in 12 cycles.
REQ-038 Back-to-back: two blocks with out_ready=1. The second ld_state occurs exactly 13 cycles after the first.
